// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends PATTERN MSB first, repeated count times with
// gap idle-zero cycles between frames. All outputs are registered.
module seq_pattern_tx #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1001,
    parameter int               GAP_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [7:0]       count_i,
    input  logic [GAP_W-1:0] gap_i,
    input  logic             abort_i,
    output logic             dout_o,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic             done_o
);

    // state | meaning
    // IDLE  | waiting for start with count != 0; outputs low
    // SEND  | a pattern bit is on dout; bit_q is its index
    // GAP   | idle zeros between frames; gap_cnt_q counts remaining gap cycles
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    localparam int              IDX_W    = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   bit_q, bit_d;
    logic [7:0]         rem_q, rem_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [GAP_W-1:0]   gap_lat_q, gap_lat_d;
    logic               dout_q, dout_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic               done_q, done_d;
    logic [IDX_W-1:0]   bit_dec;

    assign bit_dec = bit_q - IDX_W'(1);

    always_comb begin
        state_d      = state_q;
        bit_d        = bit_q;
        rem_d        = rem_q;
        gap_cnt_d    = gap_cnt_q;
        gap_lat_d    = gap_lat_q;
        dout_d       = 1'b0;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        done_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start_i && (count_i != 8'd0) && !abort_i) begin
                    state_d   = SEND;
                    rem_d     = count_i;
                    gap_lat_d = gap_i;
                    bit_d     = LAST_IDX;
                    dout_d    = PATTERN[LAST_IDX];
                    busy_d    = 1'b1;
                end
            end
            SEND: begin
                if (abort_i) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    rem_d   = 8'd0;
                end else if (bit_q != '0) begin
                    bit_d        = bit_dec;
                    dout_d       = PATTERN[bit_dec];
                    frame_done_d = (bit_dec == '0);
                end else begin
                    // rem_q is at least 1 here, so the decrement never underflows
                    rem_d = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (gap_lat_q == '0) begin
                        bit_d  = LAST_IDX;
                        dout_d = PATTERN[LAST_IDX];
                    end else begin
                        state_d   = GAP;
                        gap_cnt_d = gap_lat_q;
                    end
                end
            end
            GAP: begin
                if (abort_i) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    rem_d     = 8'd0;
                    gap_cnt_d = '0;
                end else if (gap_cnt_q == GAP_W'(1)) begin
                    state_d   = SEND;
                    gap_cnt_d = '0;
                    bit_d     = LAST_IDX;
                    dout_d    = PATTERN[LAST_IDX];
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_q        <= '0;
            rem_q        <= '0;
            gap_cnt_q    <= '0;
            gap_lat_q    <= '0;
            dout_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_q        <= bit_d;
            rem_q        <= rem_d;
            gap_cnt_q    <= gap_cnt_d;
            gap_lat_q    <= gap_lat_d;
            dout_q       <= dout_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            done_q       <= done_d;
        end
    end

    assign dout_o       = dout_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx with default 1001 pattern; per-cycle
// expected waveforms are written out by hand, cycle 1 is the leftmost bit.
module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_i;
    logic [7:0] count_i;
    logic [3:0] gap_i;
    logic       abort_i;
    logic       dout_o;
    logic       busy_o;
    logic       frame_done_o;
    logic       done_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] det_sh;
    int det_cnt;

    seq_pattern_tx dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .count_i      (count_i),
        .gap_i        (gap_i),
        .abort_i      (abort_i),
        .dout_o       (dout_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic [7:0] cnt, input logic [3:0] gp);
        start_i = 1'b1;
        count_i = cnt;
        gap_i   = gp;
        tick();
        start_i = 1'b0;
        det_sh  = 4'b0;
        det_cnt = 0;
    endtask

    // Checks cycles 1..n; optionally pokes start or abort during a given cycle.
    task automatic check_seq(input string name, input int n,
                             input logic [63:0] e_dout, input logic [63:0] e_busy,
                             input logic [63:0] e_fd, input logic [63:0] e_done,
                             input int start_at, input int abort_at);
        for (int k = 1; k <= n; k++) begin
            check($sformatf("%s dout c%0d", name, k), 32'(dout_o), 32'(e_dout[n-k]));
            check($sformatf("%s busy c%0d", name, k), 32'(busy_o), 32'(e_busy[n-k]));
            check($sformatf("%s frame_done c%0d", name, k), 32'(frame_done_o), 32'(e_fd[n-k]));
            check($sformatf("%s done c%0d", name, k), 32'(done_o), 32'(e_done[n-k]));
            det_sh = {det_sh[2:0], dout_o};
            if (det_sh == 4'b1001) begin
                det_cnt++;
                det_sh = 4'b0;
            end
            start_i = (k == start_at);
            if (k == start_at) begin
                count_i = 8'd5;
                gap_i   = 4'd3;
            end
            abort_i = (k == abort_at);
            tick();
        end
        start_i = 1'b0;
        abort_i = 1'b0;
    endtask

    initial begin
        int busy_cnt, fd_cnt, done_cnt, cyc;
        reset   = 1'b1;
        start_i = 1'b0;
        count_i = 8'd0;
        gap_i   = 4'd0;
        abort_i = 1'b0;
        det_sh  = 4'b0;
        det_cnt = 0;
        #12;
        check("reset dout", 32'(dout_o), 32'd0);
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset frame_done", 32'(frame_done_o), 32'd0);
        check("reset done", 32'(done_o), 32'd0);
        reset = 1'b0;
        tick();

        // single frame
        start_xfer(8'd1, 4'd0);
        check_seq("t1", 5, 64'b10010, 64'b11110, 64'b00010, 64'b00001, 0, 0);

        // two frames with a 2-cycle gap
        start_xfer(8'd2, 4'd2);
        check_seq("t2", 11, 64'b10010010010, 64'b11111111110,
                  64'b00010000010, 64'b00000000001, 0, 0);

        // back-to-back frames through the 1001 detector model
        start_xfer(8'd3, 4'd0);
        check_seq("t3", 13, 64'b1001100110010, 64'b1111111111110,
                  64'b0001000100010, 64'b0000000000001, 0, 0);
        check("t3 detector pulses", 32'(det_cnt), 32'd3);

        // count=0 start is ignored entirely
        start_xfer(8'd0, 4'd1);
        check_seq("t4a", 2, 64'b00, 64'b00, 64'b00, 64'b00, 0, 0);
        // a start during the transfer does not extend it
        start_xfer(8'd2, 4'd1);
        check_seq("t4b", 11, 64'b10010100100, 64'b11111111100,
                  64'b00010000100, 64'b00000000010, 3, 0);

        // abort on the second bit of the second frame
        start_xfer(8'd3, 4'd0);
        check_seq("t5", 10, 64'b1001100000, 64'b1111110000,
                  64'b0001000000, 64'b0000000000, 0, 6);

        // abort together with start in idle drops the start
        abort_i = 1'b1;
        start_xfer(8'd1, 4'd0);
        abort_i = 1'b0;
        check_seq("t5b", 3, 64'b000, 64'b000, 64'b000, 64'b000, 0, 0);

        // async reset between edges during the gap
        start_xfer(8'd2, 4'd3);
        check_seq("t6a", 5, 64'b10010, 64'b11111, 64'b00010, 64'b00000, 0, 0);
        #2 reset = 1'b1;
        #1;
        check("t6 async dout", 32'(dout_o), 32'd0);
        check("t6 async busy", 32'(busy_o), 32'd0);
        check("t6 async frame_done", 32'(frame_done_o), 32'd0);
        check("t6 async done", 32'(done_o), 32'd0);
        #2 reset = 1'b0;
        start_xfer(8'd1, 4'd0);
        check_seq("t6b", 6, 64'b100100, 64'b111100, 64'b000100, 64'b000010, 0, 0);

        // count=255 runs to completion without wrapping
        start_xfer(8'd255, 4'd0);
        busy_cnt = 0;
        fd_cnt   = 0;
        done_cnt = 0;
        cyc      = 0;
        while (done_cnt == 0 && cyc < 1100) begin
            if (busy_o) busy_cnt++;
            if (frame_done_o) fd_cnt++;
            if (done_o) done_cnt++;
            tick();
            cyc++;
        end
        check("t7 busy cycles", 32'(busy_cnt), 32'd1020);
        check("t7 frame_done pulses", 32'(fd_cnt), 32'd255);
        check("t7 done seen", 32'(done_cnt), 32'd1);
        check("t7 idle after", 32'(busy_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter: on a start request it emits a fixed PAT_W-bit pattern, MSB first, one bit per clock on `dout`. It repeats the pattern a programmable number of times with a programmable run of idle zeros between frames. It is the stimulus and transmit end for the team's serial sequence detectors. With default parameters it produces the 1001 frames consumed by the non-overlapping Mealy detector.

## Interface
- `PAT_W`, default 4: pattern length in bits, 2..16
- `PATTERN`, default 4'b1001: pattern value; bit PAT_W-1 is sent first
- `GAP_W`, default 4: width of the gap-length input
- `clk`  in  1  clock, rising-edge
- `reset`  in  1  asynchronous, active-high
- `start`  in  1  request; sampled only in IDLE
- `count`  in  8  number of frames to send; latched at accepted start
- `gap`  in  GAP_W  idle-zero cycles between frames; latched at accepted start
- `abort`  in  1  synchronous cancel
- `dout`  out  1  serial data, registered
- `busy`  out  1  high from the first bit until the transfer ends
- `frame_done`  out  1  high in the cycle `dout` carries PATTERN[0]
- `done`  out  1  one-cycle pulse after the last bit of the last frame

## Operation
- States: IDLE, SEND, GAP.
- Internal registers:
  - bit index, width clog2(PAT_W)
  - remaining-frame counter, 8 bits
  - gap counter, GAP_W bits
  - latched gap value
- IDLE:
  - `dout`=0, `busy`=0.
  - If `start`=1 and `count`!=0, latch `count` and `gap`, go to SEND.
  - In that same edge set `dout`=PATTERN[PAT_W-1] and `busy`=1.
  - If `start`=1 and `count`=0, ignore the request: no state change, no pulses.
- SEND:
  - Present PATTERN bits in descending index order, one per cycle.
  - On the edge after the cycle carrying PATTERN[0], decrement the remaining-frame counter, then branch:
    - remaining becomes 0: go to IDLE, `dout`=0, `busy`=0, `done`=1 for one cycle.
    - remaining >0 and gap=0: stay in SEND and present PATTERN[PAT_W-1] immediately, so frames are back to back.
    - remaining >0 and gap>0: go to GAP.
- GAP:
  - `dout`=0 for exactly `gap` cycles, then SEND with PATTERN[PAT_W-1].
  - `busy` stays 1 throughout.
- `start` while busy is ignored. `count` and `gap` changes while busy have no effect.
- `abort`=1 in SEND or GAP: next edge goes to IDLE with `dout`=0, `busy`=0, `frame_done`=0, and no `done` pulse.
  - `abort` has priority over every other transition.
  - `abort` in IDLE has no effect.
  - `abort` and `start` together in IDLE: `abort` wins and the start is dropped.
- All outputs are registered; no combinational path from any input to any output.

## Timing
- Reset (asynchronous, any time, including mid-frame): state IDLE, counters 0, `dout`=0, `busy`=0, `frame_done`=0, `done`=0.
- Latency: start accepted at edge E0; the first bit is valid in the cycle after E0.
- One frame occupies exactly PAT_W cycles.
- Total busy cycles for count=N, gap=G: N*PAT_W + (N-1)*G.
- `done` is asserted in the first cycle after `busy` falls (the cycle `busy`=0). A new `start` is accepted at that same edge.
- `frame_done` is high only in the last-bit cycle of each frame, N pulses per transfer. It is never high during GAP.
- count=255 is supported; the counter must not wrap or underflow.

## Test plan
- Reset, then `start`=1 for one cycle with count=1, gap=0:
  - `dout`=1,0,0,1 in cycles 1-4 with `busy`=1
  - `frame_done` high in cycle 4
  - `done`=1 and `busy`=0 in cycle 5
- count=2, gap=2:
  - `dout`=1,0,0,1,0,0,1,0,0,1
  - two `frame_done` pulses, at cycles 4 and 10
  - `busy` high for 10 cycles, `done` at cycle 11
- count=3, gap=0, with `dout` looped into the 1001 non-overlapping detector: 12 contiguous bits 100110011001 and exactly 3 detector pulses.
- `start` with count=0, then a second `start` pulse mid-transfer (count=2, gap=1): the first is ignored entirely; the second does not extend the transfer (9 busy cycles).
- `abort` in the cycle carrying the second bit of the second frame (count=3): `dout`=0 and `busy`=0 from the next cycle, no `done`, only 1 `frame_done`.
- Async `reset` pulse asserted between clock edges during GAP: all outputs 0 immediately. A following start (count=1) yields a clean 1,0,0,1.
